aes_ct_serializer: RTL

- Downstream stage of the unrolled AES-128 encryption pipeline. Tracks which pipeline slots carry real blocks. Captures each valid 128-bit ciphertext into a small FIFO and streams it out as four 32-bit words over a valid/ready interface.
- The core cannot stall, so the block issues launch credits upstream. These guarantee the FIFO never overflows.

---
 rtl/aes_ct_serializer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer
// Output stage of the unrolled AES-128 encryption pipeline. A shift register
// tracks which core pipeline slots carry real blocks. Each valid ciphertext is
// captured into a small FIFO and streamed out as four 32-bit words,
// most-significant word first, over a valid/ready handshake. Because the core
// cannot stall, launches are gated by credits so a capture always finds a free
// FIFO entry.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-high; clears all state
//   launch_valid - upstream presents a new plaintext/key to the core
//   launch_ready - a credit is available (launch accepted when both high)
//   core_ct      - registered 128-bit ciphertext from the core
//   out_data     - current ciphertext word (0 when out_valid is low)
//   out_valid    - out_data is valid
//   out_ready    - downstream accepts the word
//   out_last     - marks the 4th word of a block
//   fifo_count   - number of stored blocks
//   err_drop     - sticky flag: launch_valid seen while launch_ready was low
module aes_ct_serializer #(
  parameter int unsigned LATENCY = 12,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     launch_valid,
  output logic                     launch_ready,
  input  logic [127:0]             core_ct,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [LATENCY-1:0] track;
  logic [CW-1:0]      used;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [1:0]         wc;
  logic [127:0]       mem [DEPTH];
  logic [127:0]       head;

  logic accept;
  logic capture;
  logic word_hs;
  logic pop;

  // Credits cover both in-flight launches and stored blocks, so a capture
  // can never hit a full FIFO.
  assign launch_ready = (used < CW'(DEPTH));
  assign accept       = launch_valid && launch_ready;
  assign capture      = track[LATENCY-1];

  assign out_valid = (fifo_count != '0);
  assign out_last  = out_valid && (wc == 2'd3);
  assign word_hs   = out_valid && out_ready;
  assign pop       = word_hs && (wc == 2'd3);
  assign head      = mem[rd_ptr];

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (wc)
        2'd0:    out_data = head[127:96];
        2'd1:    out_data = head[95:64];
        2'd2:    out_data = head[63:32];
        default: out_data = head[31:0];
      endcase
    end
  end

  // Shift-and-or form keeps LATENCY == 1 legal (no empty slice).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      track <= '0;
    end else begin
      track <= (track << 1) | LATENCY'(accept);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (capture) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage is not reset; out_data is masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= core_ct;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc <= '0;
    end else if (word_hs) begin
      wc <= wc + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_drop <= 1'b0;
    end else if (launch_valid && !launch_ready) begin
      err_drop <= 1'b1;
    end
  end

endmodule
